// File: rtl/done_collector_pkg.sv
// Shared types for the done collector: channel codes, the queued record layout
// and the fixed-priority grant-to-channel encoder.
package done_collector_pkg;

    localparam int DEF_COUNT_W = 7;

    typedef enum logic [1:0] {
        CH_NONE = 2'd0,
        CH_1    = 2'd1,
        CH_2    = 2'd2,
        CH_3    = 2'd3
    } chan_e;

    typedef struct packed {
        chan_e                  chan;
        logic [DEF_COUNT_W-1:0] count;
    } record_t;

    // grant is one-hot (bit 0 = channel 1) or zero.
    function automatic chan_e chan_code(input logic [2:0] grant);
        if (grant[0])      return CH_1;
        else if (grant[1]) return CH_2;
        else if (grant[2]) return CH_3;
        else               return CH_NONE;
    endfunction

endpackage

// File: rtl/done_collector_if.sv
// Channel inputs and record stream of the done collector; slave is the
// collector side, master is the go/delay block plus reporting logic.
interface done_collector_if
    import done_collector_pkg::*;
#(
    parameter int COUNT_W = DEF_COUNT_W,
    parameter int DEPTH   = 4
);
    logic               done_1, done_2, done_3;
    logic [COUNT_W-1:0] count_1, count_2, count_3;
    logic               kill_ltchd;
    logic               batch_clr;
    logic               out_ready;
    logic               out_valid;
    logic [1:0]         out_chan;
    logic [COUNT_W-1:0] out_count;
    logic [$clog2(DEPTH):0] fifo_level;
    logic               overflow;
    logic               all_done;

    modport slave (
        input  done_1, done_2, done_3, count_1, count_2, count_3,
        input  kill_ltchd, batch_clr, out_ready,
        output out_valid, out_chan, out_count, fifo_level, overflow, all_done
    );

    modport master (
        output done_1, done_2, done_3, count_1, count_2, count_3,
        output kill_ltchd, batch_clr, out_ready,
        input  out_valid, out_chan, out_count, fifo_level, overflow, all_done
    );
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; push when full and pop when empty are ignored.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        full     = (level_q == LVL_W'(DEPTH));
        empty    = (level_q == '0);
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        rd_data = mem_q[rd_ptr_q];
        level   = level_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is not reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/done_collector.sv
// Captures each channel's count on its done rising edge, queues {channel, count}
// records for the reporting logic and tracks batch completion and drops.
module done_collector
    import done_collector_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic            clk,
    input  logic            reset,
    done_collector_if.slave bus
);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int REC_W = 2 + COUNT_W;

    logic [2:0]         done_in, fire, grant;
    logic [COUNT_W-1:0] cnt_in [3];
    logic [COUNT_W-1:0] grant_cnt;
    logic [2:0]         done_d_q, done_d_d, pend_q, pend_d, seen_q, seen_d;
    logic [COUNT_W-1:0] pend_cnt_q [3];
    logic [COUNT_W-1:0] pend_cnt_d [3];
    logic               overflow_q, overflow_d, all_done_q, all_done_d;
    logic [REC_W-1:0]   last_q, last_d, push_data, head_data;
    logic               push, pop, full, empty;
    logic [LVL_W-1:0]   level;

    always_comb begin
        done_in   = {bus.done_3, bus.done_2, bus.done_1};
        cnt_in[0] = bus.count_1;
        cnt_in[1] = bus.count_2;
        cnt_in[2] = bus.count_3;
        fire      = done_in & ~done_d_q & {3{~bus.kill_ltchd}};

        // Lowest set pending bit wins: channel 1 over 2 over 3.
        grant     = pend_q & (~pend_q + 3'd1);
        push      = (|pend_q) & ~full;
        pop       = ~empty & bus.out_ready;
        grant_cnt = '0;
        for (int i = 0; i < 3; i++) begin
            if (grant[i]) grant_cnt = pend_cnt_q[i];
        end
        push_data = {chan_code(grant), grant_cnt};

        done_d_d   = done_in;
        pend_d     = push ? (pend_q & ~grant) : pend_q;
        pend_cnt_d = pend_cnt_q;
        // A slot still holding an unpushed capture keeps it; the newer edge is lost.
        overflow_d = overflow_q | (|(fire & pend_q));
        for (int i = 0; i < 3; i++) begin
            if (fire[i] && !pend_q[i]) begin
                pend_d[i]     = 1'b1;
                pend_cnt_d[i] = cnt_in[i];
            end
        end

        seen_d     = push ? (seen_q | grant) : seen_q;
        all_done_d = &seen_d;
        if (all_done_d) seen_d = '0;
        if (bus.batch_clr) begin
            seen_d     = '0;
            all_done_d = 1'b0;
            overflow_d = 1'b0;
        end

        last_d = empty ? last_q : head_data;
    end

    // The head fields hold the last shown record once the FIFO drains.
    always_comb begin
        bus.out_valid                 = ~empty;
        {bus.out_chan, bus.out_count} = empty ? last_q : head_data;
        bus.fifo_level                = level;
        bus.overflow                  = overflow_q;
        bus.all_done                  = all_done_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_d_q   <= '0;
            pend_q     <= '0;
            seen_q     <= '0;
            overflow_q <= 1'b0;
            all_done_q <= 1'b0;
            last_q     <= '0;
            for (int i = 0; i < 3; i++) pend_cnt_q[i] <= '0;
        end else begin
            done_d_q   <= done_d_d;
            pend_q     <= pend_d;
            seen_q     <= seen_d;
            overflow_q <= overflow_d;
            all_done_q <= all_done_d;
            last_q     <= last_d;
            for (int i = 0; i < 3; i++) pend_cnt_q[i] <= pend_cnt_d[i];
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (push_data),
        .pop     (pop),
        .rd_data (head_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

endmodule

// File: tb/tb_done_collector.sv
// Directed scenarios followed by random traffic, every cycle compared with a
// queue-based model of the collector's capture, queueing and batch rules.
module tb_done_collector;
    import done_collector_pkg::*;

    localparam int DEPTH   = 4;
    localparam int COUNT_W = DEF_COUNT_W;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    done_collector_if #(.COUNT_W(COUNT_W), .DEPTH(DEPTH)) bus ();

    done_collector #(
        .DEPTH   (DEPTH),
        .COUNT_W (COUNT_W)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int ad_pulses = 0;

    record_t mq [$];
    int      m_pcnt [3];
    bit      m_pend [3];
    bit      m_prev [3];
    bit      m_seen [3];
    bit      m_ovf;
    bit      m_ad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit [2:0] d;
        int       cnt [3];
        bit       was_pend [3];
        int       sel;
        bit       do_push, do_pop, ovf_new;
        record_t  r;
        d      = {bus.done_3, bus.done_2, bus.done_1};
        cnt[0] = int'(bus.count_1);
        cnt[1] = int'(bus.count_2);
        cnt[2] = int'(bus.count_3);
        if (reset) begin
            mq.delete();
            m_pend = '{default: 1'b0};
            m_seen = '{default: 1'b0};
            m_prev = '{default: 1'b0};
            m_ovf  = 1'b0;
            m_ad   = 1'b0;
            return;
        end
        sel = -1;
        for (int i = 2; i >= 0; i--) if (m_pend[i]) sel = i;
        do_push  = (sel >= 0) && (mq.size() < DEPTH);
        do_pop   = (mq.size() > 0) && bus.out_ready;
        was_pend = m_pend;
        ovf_new  = 1'b0;
        r        = '0;
        if (do_push) begin
            r.chan      = chan_e'(2'(sel + 1));
            r.count     = COUNT_W'(m_pcnt[sel]);
            m_pend[sel] = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            if (d[i] && !m_prev[i] && !bus.kill_ltchd) begin
                if (was_pend[i]) ovf_new = 1'b1;
                else begin
                    m_pend[i] = 1'b1;
                    m_pcnt[i] = cnt[i];
                end
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(r);
        m_ad = 1'b0;
        if (do_push) m_seen[sel] = 1'b1;
        if (m_seen[0] && m_seen[1] && m_seen[2]) begin
            m_ad   = 1'b1;
            m_seen = '{default: 1'b0};
        end
        m_ovf = m_ovf | ovf_new;
        if (bus.batch_clr) begin
            m_seen = '{default: 1'b0};
            m_ad   = 1'b0;
            m_ovf  = 1'b0;
        end
        for (int i = 0; i < 3; i++) m_prev[i] = d[i];
    endtask

    task automatic compare();
        check("out_valid", bus.out_valid, mq.size() != 0);
        check("fifo_level", bus.fifo_level, mq.size());
        check("overflow", bus.overflow, m_ovf);
        check("all_done", bus.all_done, m_ad);
        if (mq.size() != 0) begin
            check("out_chan", bus.out_chan, mq[0].chan);
            check("out_count", bus.out_count, mq[0].count);
        end
        ad_pulses += int'(bus.all_done);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic set_done(input int ch, input bit lvl, input int cnt);
        case (ch)
            1: begin bus.done_1 = lvl; bus.count_1 = COUNT_W'(cnt); end
            2: begin bus.done_2 = lvl; bus.count_2 = COUNT_W'(cnt); end
            default: begin bus.done_3 = lvl; bus.count_3 = COUNT_W'(cnt); end
        endcase
    endtask

    task automatic pulse(input int ch, input int cnt);
        set_done(ch, 1'b1, cnt);
        tick();
        set_done(ch, 1'b0, cnt);
        tick();
    endtask

    task automatic clear_batch();
        bus.batch_clr = 1'b1;
        tick();
        bus.batch_clr = 1'b0;
    endtask

    initial begin
        int ad0;
        reset          = 1'b1;
        bus.done_1     = 1'b0;
        bus.done_2     = 1'b0;
        bus.done_3     = 1'b0;
        bus.count_1    = '0;
        bus.count_2    = '0;
        bus.count_3    = '0;
        bus.kill_ltchd = 1'b0;
        bus.batch_clr  = 1'b0;
        bus.out_ready  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_chan", bus.out_chan, 0);
        check("rst_count", bus.out_count, 0);
        check("rst_valid", bus.out_valid, 0);

        // Single event: count sampled on the edge, visible two cycles later.
        bus.out_ready = 1'b1;
        set_done(2, 1'b1, 45);
        tick();
        check("single_n_valid", bus.out_valid, 0);
        bus.count_2 = 7'd99;
        tick();
        check("single_valid", bus.out_valid, 1);
        check("single_chan", bus.out_chan, 2);
        check("single_count", bus.out_count, 45);
        tick();
        check("single_drained", bus.fifo_level, 0);
        set_done(2, 1'b0, 0);
        tick();

        // Simultaneous events: pushed on consecutive edges in channel order.
        clear_batch();
        bus.out_ready = 1'b0;
        set_done(1, 1'b1, 10);
        set_done(2, 1'b1, 20);
        set_done(3, 1'b1, 30);
        tick();
        bus.count_1 = 7'h55;
        bus.count_2 = 7'h55;
        bus.count_3 = 7'h55;
        tick();
        check("sim_first_chan", bus.out_chan, 1);
        check("sim_first_count", bus.out_count, 10);
        tick();
        tick();
        check("sim_level", bus.fifo_level, 3);
        check("sim_all_done", bus.all_done, 1);
        tick();
        check("sim_all_done_once", bus.all_done, 0);
        bus.out_ready = 1'b1;
        set_done(1, 1'b0, 0);
        set_done(2, 1'b0, 0);
        set_done(3, 1'b0, 0);
        repeat (4) tick();
        check("sim_drained", bus.fifo_level, 0);

        // Backpressure: fill to DEPTH, hold a fifth pending, then overflow it.
        clear_batch();
        bus.out_ready = 1'b0;
        pulse(1, 1);
        pulse(2, 2);
        pulse(3, 3);
        pulse(1, 4);
        pulse(2, 5);
        check("bp_full", bus.fifo_level, 4);
        pulse(2, 6);
        check("bp_overflow", bus.overflow, 1);
        check("bp_level", bus.fifo_level, 4);
        check("bp_head_count", bus.out_count, 1);
        bus.out_ready = 1'b1;
        repeat (4) tick();
        check("bp_fifth_chan", bus.out_chan, 2);
        check("bp_fifth_count", bus.out_count, 5);
        repeat (3) tick();
        check("bp_drained", bus.fifo_level, 0);
        clear_batch();
        check("bp_ovf_cleared", bus.overflow, 0);

        // Kill gating: edges under kill are dropped, not deferred.
        bus.out_ready  = 1'b0;
        bus.kill_ltchd = 1'b1;
        set_done(3, 1'b1, 77);
        repeat (3) tick();
        check("kill_level", bus.fifo_level, 0);
        bus.kill_ltchd = 1'b0;
        repeat (2) tick();
        check("kill_no_defer", bus.fifo_level, 0);
        set_done(3, 1'b0, 77);
        tick();
        set_done(3, 1'b1, 77);
        tick();
        tick();
        check("kill_rearm_level", bus.fifo_level, 1);
        check("kill_rearm_chan", bus.out_chan, 3);
        bus.out_ready = 1'b1;
        set_done(3, 1'b0, 77);
        tick();
        tick();

        // Mid-operation reset discards queued and pending records.
        clear_batch();
        bus.out_ready = 1'b0;
        pulse(1, 11);
        pulse(2, 12);
        pulse(1, 13);
        check("mr_level", bus.fifo_level, 3);
        set_done(3, 1'b1, 14);
        tick();
        ad0   = ad_pulses;
        reset = 1'b1;
        set_done(3, 1'b0, 14);
        tick();
        reset = 1'b0;
        check("mr_valid", bus.out_valid, 0);
        check("mr_level0", bus.fifo_level, 0);
        check("mr_chan", bus.out_chan, 0);
        repeat (4) tick();
        check("mr_no_all_done", ad_pulses - ad0, 0);

        // batch_clr between reports prevents completion of that batch.
        bus.out_ready = 1'b1;
        clear_batch();
        pulse(1, 21);
        pulse(2, 22);
        clear_batch();
        ad0 = ad_pulses;
        pulse(3, 23);
        tick();
        check("bc_no_all_done", ad_pulses - ad0, 0);
        pulse(1, 24);
        pulse(2, 25);
        pulse(3, 26);
        tick();
        check("bc_one_all_done", ad_pulses - ad0, 1);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) bus.done_1 = ~bus.done_1;
            if ($urandom_range(3) == 0) bus.done_2 = ~bus.done_2;
            if ($urandom_range(3) == 0) bus.done_3 = ~bus.done_3;
            bus.count_1 = COUNT_W'($urandom);
            bus.count_2 = COUNT_W'($urandom);
            bus.count_3 = COUNT_W'($urandom);
            if ($urandom_range(19) == 0) bus.kill_ltchd = ~bus.kill_ltchd;
            bus.batch_clr = ($urandom_range(19) == 0);
            bus.out_ready = ($urandom_range(1) == 0);
            reset         = ($urandom_range(99) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/done_collector.md
Name: done_collector

Overview:
- Downstream consumer of the three-channel go/delay block.
- Detects each channel's done rising edge and captures that channel's 7-bit count on the same edge.
- Queues {channel, count} records in a small FIFO and presents them on a valid/ready interface to the reporting logic.
- Also tracks batch completion (all three channels reported), gates capture while the kill latch is set, and flags dropped events.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- COUNT_W, 7, width of each channel count.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- done_1  in  1  channel 1 done level
- done_2  in  1  channel 2 done level
- done_3  in  1  channel 3 done level
- count_1  in  COUNT_W  channel 1 count
- count_2  in  COUNT_W  channel 2 count
- count_3  in  COUNT_W  channel 3 count
- kill_ltchd  in  1  latched kill; blocks new captures while high
- batch_clr  in  1  clears batch tracking and the overflow flag
- out_ready  in  1  consumer accepts the head record
- out_valid  out  1  FIFO not empty
- out_chan  out  2  channel of head record: 1, 2 or 3 (0 never emitted)
- out_count  out  COUNT_W  count captured for the head record
- fifo_level  out  clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: an event was dropped
- all_done  out  1  one-cycle pulse when all three channels have reported in the current batch

Behaviour:
- Reset (synchronous, clk edge with reset=1) clears: FIFO pointers, fifo_level=0, out_valid=0, out_chan=0, out_count=0, overflow=0, all_done=0, pending flags, done_d registers, batch flags.
- Reset wins over every other input in the same cycle, including mid-transfer; any record not yet popped is discarded.
- Edge detect:
  - done_d_n <= done_n every cycle.
  - An event on channel n is done_n & ~done_d_n & ~kill_ltchd.
  - Edges arriving while kill_ltchd=1 are discarded permanently, not deferred.
- Capture:
  - On an event, set pend_n and pend_cnt_n <= count_n, sampled on that same clock edge.
  - If pend_n is already set: set overflow; the old captured value is kept and the new one dropped.
- FIFO write:
  - One push per cycle, when FIFO is not full and any pend_n is set.
  - Fixed priority ch1 > ch2 > ch3.
  - The selected pend_n is cleared on push.
  - Full blocks the push even if a pop occurs in the same cycle.
- FIFO read:
  - Show-ahead: out_chan/out_count reflect the head entry whenever out_valid=1.
  - Pop on out_valid & out_ready.
  - When empty, out_chan/out_count hold their last value and must not be interpreted.
- Level and pointers:
  - fifo_level: +1 on push only, -1 on pop only, unchanged on both or neither.
  - Pointers wrap modulo DEPTH.
- Latency: event at clock edge N -> earliest push at edge N+1 -> out_valid high after edge N+1, i.e. in cycle N+2.
- Simultaneous events on all three channels at edge N: pushed at N+1, N+2, N+3 (ch1, ch2, ch3), provided space is available.
- Batch tracking:
  - seen_n is set when channel n's record is pushed.
  - When seen_1..3 would all be 1, all_done pulses for one cycle (the cycle after the completing push) and seen_1..3 clear.
  - batch_clr clears seen_1..3 and overflow.
  - If a push and batch_clr occur in the same cycle, batch_clr wins and the pushed channel's seen bit ends at 0. The record itself is still queued.
- Pending entries are unaffected by kill_ltchd or batch_clr; they drain normally.

Decomposition:
- Package done_collector_pkg:
  - COUNT_W default.
  - Channel codes CH_NONE=2'd0, CH_1=2'd1, CH_2=2'd2, CH_3=2'd3.
  - Record typedef {chan[1:0], count[COUNT_W-1:0]}.
- Sub-module sync_fifo (parameters DEPTH and width): push/pop/full/empty/level, show-ahead read, synchronous active-high reset.
- Top level holds edge detect, pending registers, priority select, batch/overflow logic.

Test Plan:
- Reset, then single event: done_2 rises with count_2=7'd45, out_ready=1 -> out_valid in cycle N+2 with out_chan=2, out_count=45; popped next edge; fifo_level returns to 0.
- Simultaneous events: done_1/2/3 rise together with counts 10/20/30, out_ready=0 -> records ch1=10, ch2=20, ch3=30 in that order; fifo_level=3; all_done pulses once after the third push.
- Backpressure overflow (DEPTH=4, out_ready=0):
  - Generate 5 records over time -> fifo_level saturates at 4 and the 5th stays pending.
  - Another edge on that same channel -> overflow=1 and the original captured count is preserved.
  - Raise out_ready -> all 5 drain in order.
- Kill gating: kill_ltchd=1 while done_3 rises -> no record, fifo_level unchanged; drop kill_ltchd with done_3 still high -> still no record until done_3 falls and rises again.
- Mid-operation reset: 3 records queued, assert reset for one cycle -> out_valid=0, fifo_level=0, overflow=0, and all_done does not pulse afterwards.
- batch_clr: ch1 and ch2 reported, pulse batch_clr, then ch3 reports -> no all_done; after ch1, ch2, ch3 all report again -> single all_done pulse.
